eth_tx_arbiter: RTL and testbench
=================================

Name: eth_tx_arbiter

Overview:
Shares the single RMII transmit path (eth_txen/eth_txd, fed through the transmit serializer) between NUM_REQ frame sources. Examples are a loopback/echo path and a status-reply generator. The arbiter grants whole frames round-robin, forwards the granted source's dibit stream with one cycle of latency, and enforces the Ethernet inter-packet gap. It also guards against a stuck grant and against runaway frames.

Parameters:
NUM_REQ, 2, number of frame sources (≥2)
IFG_CYCLES, 48, idle cycles after each frame (96 bit times at 2 bits/cycle)
GRANT_TIMEOUT, 256, cycles a granted source may take to start its frame before the grant is revoked
MAX_DIBITS, 6104, maximum dibits per frame (1526 bytes incl. preamble/SFD); longer frames are truncated

Ports:
clk  in  1  50 MHz eth_refclk domain
rst  in  1  synchronous reset, active-low
req  in  NUM_REQ  per-source frame request, level
axiiv  in  NUM_REQ  per-source dibit valid
axiid  in  2*NUM_REQ  per-source dibit; source i on bits [2i+1:2i], MSB-first dibit order already applied
gnt  out  NUM_REQ  one-hot grant, registered
axiov  out  1  forwarded dibit valid to transmitter
axiod  out  2  forwarded dibit
busy  out  1  high in any state other than IDLE
frame_count  out  16  completed frames forwarded (incl. truncated)
trunc  out  1  one-cycle pulse when a frame is cut at MAX_DIBITS

Behaviour:
- Reset: rst==0 at a clk edge forces the following:
  - state IDLE; gnt=0; axiov=0; axiod=0; busy=0; frame_count=0; trunc=0.
  - rr pointer=0; timers=0.
  - This applies mid-frame too: the frame is aborted, with no count and no gap.
- All outputs are registered. State machine IDLE -> GRANT -> XFER -> GAP -> IDLE; w = index of the current winner.
- IDLE:
  - If req!=0, select the first i with req[i]=1, searching from ptr upward and wrapping modulo NUM_REQ.
  - Next edge: gnt[w]=1, state GRANT, wait timer=0.
  - Request seen at edge n gives gnt visible after edge n+1.
- GRANT:
  - axiiv[w]=1 -> state XFER; that dibit is forwarded (axiov=1, axiod=axiid[w]) at the same edge; dibit counter=1.
  - req[w]=0 with axiiv[w]=0 -> gnt=0, ptr=(w+1)%NUM_REQ, IDLE (withdrawn request, no gap).
  - Timer reaches GRANT_TIMEOUT-1 with no valid -> gnt=0, ptr advance, IDLE.
  - Valid and timeout on the same cycle: valid wins.
- XFER:
  - Each edge: axiov<=axiiv[w], axiod<=axiid[w]. Latency is exactly 1 cycle.
  - req[w] is ignored; the frame end is defined only by axiiv[w] falling.
  - axiiv[w]=0 -> axiov=0, gnt=0, frame_count+1 (wraps 0xFFFF->0), ptr=(w+1)%NUM_REQ, state GAP, gap counter=0.
  - If the dibit counter equals MAX_DIBITS while axiiv[w]=1: that dibit is not forwarded; axiov=0, gnt=0, trunc=1 for one cycle, frame_count+1, ptr advance, GAP.
  - The source must drop axiiv on seeing gnt low; its remaining dibits are discarded.
- GAP: axiov=0 and all req ignored for IFG_CYCLES cycles. On the last gap cycle go to IDLE; arbitration resumes the following edge.
- axiiv/axiid from non-granted sources are ignored in every state and never reach axiod.
- axiod is 0 whenever axiov=0.
- Back-to-back: a source that holds req continuously is served again only after every other requesting source has had one grant.

Test Plan:
- Single source: req[0]=1 at cycle 0; axiiv[0] high for 64 dibits from cycle 3 -> gnt=01 from cycle 1; axiov high cycles 4–67 with axiod matching input one cycle delayed; frame_count=1; busy stays high until 48 cycles after axiov falls.
- Contention: req=11 held continuously, each source sends 8-dibit frames -> grants alternate 01,10,01,10; no gnt asserted during any 48-cycle gap; axiod never carries the non-granted source's data.
- Timeout: req[1]=1, axiiv[1] never asserted -> gnt[1] drops after 256 cycles, no axiov, frame_count unchanged, then req[0] served immediately with no gap.
- Truncation: granted source holds axiiv for 7000 cycles -> exactly 6104 dibits forwarded, trunc single-cycle pulse, frame_count+1, gap follows.
- Reset mid-frame: rst=0 for one cycle during XFER at dibit 20 -> next cycle gnt=0, axiov=0, frame_count=0, state IDLE; a new req is granted after 1 cycle with no gap.
- Wrap: preload via 65536 short frames (or force) -> frame_count goes 0xFFFF -> 0x0000.

Source files
------------

// File: rtl/eth_tx_arbiter_if.sv
// Bundle between the frame sources and the RMII transmit arbiter.
// Handshake: gnt[i] is the ready for source i. A dibit is transferred on every edge where
// gnt[i] && axiiv[i]. axiiv falling ends the frame. A source that sees gnt[i] low must drop axiiv[i].
interface eth_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   axiiv;
    logic [2*NUM_REQ-1:0] axiid;
    logic [NUM_REQ-1:0]   gnt;
    logic                 axiov;
    logic [1:0]           axiod;
    logic                 busy;
    logic [15:0]          frame_count;
    logic                 trunc;
    logic [1:0]           state_dbg;

    modport master (
        output req, axiiv, axiid,
        input  gnt, axiov, axiod, busy, frame_count, trunc, state_dbg
    );

    modport slave (
        input  req, axiiv, axiid,
        output gnt, axiov, axiod, busy, frame_count, trunc, state_dbg
    );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Round-robin whole-frame arbiter for the RMII transmit path.
// It also enforces the inter-packet gap, grant timeout and frame length limit.
module eth_tx_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int IFG_CYCLES    = 48,
    parameter int GRANT_TIMEOUT = 256,
    parameter int MAX_DIBITS    = 6104
) (
    input  logic clk,
    input  logic rst,
    eth_tx_arbiter_if.slave bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(GRANT_TIMEOUT + 1);
    localparam int DW = $clog2(MAX_DIBITS + 1);
    localparam int GW = $clog2(IFG_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_XFER  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t             state_q;
    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      w_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic               axiov_q;
    logic [1:0]         axiod_q;
    logic               busy_q;
    logic [15:0]        frame_cnt_q;
    logic               trunc_q;
    logic [TW-1:0]      wait_q;
    logic [DW-1:0]      dibit_q;
    logic [GW-1:0]      gap_q;

    logic [PW-1:0]      sel;
    logic               found;
    logic [PW:0]        cand;
    logic [PW-1:0]      nxt_ptr;
    logic [1:0]         dat_w;
    logic               vld_w;

    // First requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        sel   = ptr_q;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NUM_REQ)) cand = cand - (PW+1)'(NUM_REQ);
            if (!found && bus.req[cand[PW-1:0]]) begin
                sel   = cand[PW-1:0];
                found = 1'b1;
            end
        end
    end

    assign nxt_ptr = (w_q == PW'(NUM_REQ - 1)) ? '0 : w_q + PW'(1);
    assign vld_w   = bus.axiiv[w_q];
    assign dat_w   = bus.axiid[{w_q, 1'b0} +: 2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            w_q         <= '0;
            gnt_q       <= '0;
            axiov_q     <= 1'b0;
            axiod_q     <= 2'b00;
            busy_q      <= 1'b0;
            frame_cnt_q <= 16'h0000;
            trunc_q     <= 1'b0;
            wait_q      <= '0;
            dibit_q     <= '0;
            gap_q       <= '0;
        end else begin
            trunc_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|bus.req) begin
                        w_q     <= sel;
                        gnt_q   <= NUM_REQ'(1) << sel;
                        wait_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // A valid dibit takes priority over both withdrawal and timeout.
                    if (vld_w) begin
                        axiov_q <= 1'b1;
                        axiod_q <= dat_w;
                        dibit_q <= DW'(1);
                        state_q <= S_XFER;
                    end else if (!bus.req[w_q] || wait_q == TW'(GRANT_TIMEOUT - 1)) begin
                        gnt_q   <= '0;
                        ptr_q   <= nxt_ptr;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        wait_q <= wait_q + TW'(1);
                    end
                end
                S_XFER: begin
                    if (!vld_w || dibit_q == DW'(MAX_DIBITS)) begin
                        axiov_q     <= 1'b0;
                        axiod_q     <= 2'b00;
                        gnt_q       <= '0;
                        trunc_q     <= vld_w;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        ptr_q       <= nxt_ptr;
                        gap_q       <= '0;
                        state_q     <= S_GAP;
                    end else begin
                        axiov_q <= 1'b1;
                        axiod_q <= dat_w;
                        dibit_q <= dibit_q + DW'(1);
                    end
                end
                S_GAP: begin
                    if (gap_q == GW'(IFG_CYCLES - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.axiov       = axiov_q;
    assign bus.axiod       = axiod_q;
    assign bus.busy        = busy_q;
    assign bus.frame_count = frame_cnt_q;
    assign bus.trunc       = trunc_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter covering grant, transfer, gap, timeout, truncation, reset and wrap.
module tb_eth_tx_arbiter;
    localparam int N = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #10 clk = ~clk;

    eth_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    eth_tx_arbiter #(
        .NUM_REQ(N), .IFG_CYCLES(48), .GRANT_TIMEOUT(256), .MAX_DIBITS(6104)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        bus.req   = '0;
        bus.axiiv = '0;
        bus.axiid = '0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (bus.gnt !== 2'b00 || bus.axiov !== 1'b0 || bus.axiod !== 2'b00 || bus.busy !== 1'b0 ||
            bus.frame_count !== 16'h0000 || bus.trunc !== 1'b0 || bus.state_dbg !== 2'd0) begin
            bad++;
            $display("FAIL reset_state got gnt=%b v=%b d=%b busy=%b cnt=%h trunc=%b st=%0d exp all zero",
                     bus.gnt, bus.axiov, bus.axiod, bus.busy, bus.frame_count, bus.trunc, bus.state_dbg);
        end
    endtask

    task automatic test_single();
        logic [1:0] d;
        do_reset();
        bus.req = 2'b01;
        tick();
        total++;
        if (bus.gnt !== 2'b01 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL single_grant got gnt=%b busy=%b exp 01/1", bus.gnt, bus.busy);
        end
        for (int i = 0; i < 64; i++) begin
            d = 2'(i ^ (i >> 2));
            bus.axiiv = 2'b11;
            bus.axiid = {~d, d};
            tick();
            total++;
            if (bus.axiov !== 1'b1 || bus.axiod !== d) begin
                bad++; $display("FAIL single_data[%0d] got v=%b d=%b exp 1/%b", i, bus.axiov, bus.axiod, d);
            end
        end
        bus.axiiv = 2'b10;
        bus.req   = 2'b00;
        tick();
        total++;
        if (bus.axiov !== 1'b0 || bus.axiod !== 2'b00 || bus.gnt !== 2'b00 || bus.frame_count !== 16'd1 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL single_end got v=%b d=%b gnt=%b cnt=%0d busy=%b exp 0/00/00/1/1",
                            bus.axiov, bus.axiod, bus.gnt, bus.frame_count, bus.busy);
        end
        for (int g = 1; g <= 48; g++) begin
            tick();
            total++;
            if (bus.busy !== (g < 48) || bus.axiov !== 1'b0) begin
                bad++; $display("FAIL single_gap[%0d] got busy=%b v=%b exp busy=%b v=0", g, bus.busy, bus.axiov, g < 48);
            end
        end
    endtask

    task automatic test_contention();
        int         src;
        logic [1:0] exp_g;
        logic [1:0] d;
        logic [3:0] v;
        logic [1:0] iv;
        do_reset();
        bus.req = 2'b11;
        tick();
        for (int f = 0; f < 4; f++) begin
            src   = f % 2;
            exp_g = 2'(1 << src);
            total++;
            if (bus.gnt !== exp_g) begin
                bad++; $display("FAIL rr_grant[%0d] got gnt=%b exp %b", f, bus.gnt, exp_g);
            end
            for (int i = 0; i < 8; i++) begin
                d = 2'(i + f);
                v = {~d, ~d};
                v[2*src +: 2] = d;
                bus.axiid = v;
                bus.axiiv = 2'b11;
                tick();
                total++;
                if (bus.axiov !== 1'b1 || bus.axiod !== d || bus.gnt !== exp_g) begin
                    bad++; $display("FAIL rr_data[%0d.%0d] got v=%b d=%b gnt=%b exp 1/%b/%b",
                                    f, i, bus.axiov, bus.axiod, bus.gnt, d, exp_g);
                end
            end
            iv = 2'b11;
            iv[src] = 1'b0;
            bus.axiiv = iv;
            tick();
            total++;
            if (bus.gnt !== 2'b00 || bus.axiov !== 1'b0 || bus.frame_count !== 16'(f + 1)) begin
                bad++; $display("FAIL rr_end[%0d] got gnt=%b v=%b cnt=%0d exp 00/0/%0d",
                                f, bus.gnt, bus.axiov, bus.frame_count, f + 1);
            end
            for (int g = 0; g < 48; g++) begin
                tick();
                total++;
                if (bus.gnt !== 2'b00 || bus.axiov !== 1'b0 || bus.axiod !== 2'b00) begin
                    bad++; $display("FAIL rr_gap[%0d.%0d] got gnt=%b v=%b d=%b exp 00/0/00",
                                    f, g, bus.gnt, bus.axiov, bus.axiod);
                end
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.req = 2'b10;
        tick();
        total++;
        if (bus.gnt !== 2'b10) begin
            bad++; $display("FAIL to_grant got gnt=%b exp 10", bus.gnt);
        end
        for (int t = 1; t <= 255; t++) begin
            if (t == 200) bus.req = 2'b11;
            tick();
            total++;
            if (bus.gnt !== 2'b10 || bus.axiov !== 1'b0) begin
                bad++; $display("FAIL to_hold[%0d] got gnt=%b v=%b exp 10/0", t, bus.gnt, bus.axiov);
            end
        end
        tick();
        total++;
        if (bus.gnt !== 2'b00 || bus.busy !== 1'b0 || bus.frame_count !== 16'd0 || bus.axiov !== 1'b0) begin
            bad++; $display("FAIL to_revoke got gnt=%b busy=%b cnt=%0d v=%b exp 00/0/0/0",
                            bus.gnt, bus.busy, bus.frame_count, bus.axiov);
        end
        tick();
        total++;
        if (bus.gnt !== 2'b01) begin
            bad++; $display("FAIL to_next_grant got gnt=%b exp 01", bus.gnt);
        end
        bus.req = 2'b00;
        tick();
        total++;
        if (bus.gnt !== 2'b00 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL withdraw got gnt=%b busy=%b exp 00/0", bus.gnt, bus.busy);
        end
    endtask

    task automatic test_truncation();
        int         fwd;
        int         tr;
        int         trunc_at;
        logic [1:0] d;
        logic       exp_v;
        logic [1:0] exp_d;
        fwd = 0; tr = 0; trunc_at = 0;
        do_reset();
        bus.req = 2'b01;
        tick();
        total++;
        if (bus.gnt !== 2'b01) begin
            bad++; $display("FAIL tr_grant got gnt=%b exp 01", bus.gnt);
        end
        bus.req = 2'b00;
        for (int k = 1; k <= 7000; k++) begin
            d = 2'((k * 3) ^ (k >> 2));
            bus.axiiv = 2'b01;
            bus.axiid = {2'b11, d};
            tick();
            exp_v = (k <= 6104);
            exp_d = exp_v ? d : 2'b00;
            total++;
            if (bus.axiov !== exp_v || bus.axiod !== exp_d) begin
                bad++; $display("FAIL tr_data[%0d] got v=%b d=%b exp %b/%b", k, bus.axiov, bus.axiod, exp_v, exp_d);
            end
            if (bus.axiov === 1'b1) fwd++;
            if (bus.trunc === 1'b1) begin tr++; trunc_at = k; end
            if (k == 6152 || k == 6153) begin
                total++;
                if (bus.busy !== (k == 6152)) begin
                    bad++; $display("FAIL tr_gap_busy[%0d] got %b exp %b", k, bus.busy, k == 6152);
                end
            end
        end
        bus.axiiv = 2'b00;
        total++;
        if (fwd != 6104 || tr != 1 || trunc_at != 6105) begin
            bad++; $display("FAIL tr_counts got fwd=%0d pulses=%0d at=%0d exp 6104/1/6105", fwd, tr, trunc_at);
        end
        total++;
        if (bus.frame_count !== 16'd1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL tr_final got cnt=%0d busy=%b exp 1/0", bus.frame_count, bus.busy);
        end
    endtask

    // Runs straight after truncation: frame_count is 1 and ptr points at source 1.
    task automatic test_reset_midframe();
        bus.req = 2'b01;
        tick();
        total++;
        if (bus.gnt !== 2'b01) begin
            bad++; $display("FAIL mr_grant got gnt=%b exp 01", bus.gnt);
        end
        for (int i = 0; i < 20; i++) begin
            bus.axiiv = 2'b01;
            bus.axiid = 4'(i & 3);
            tick();
        end
        total++;
        if (bus.axiov !== 1'b1 || bus.axiod !== 2'd3) begin
            bad++; $display("FAIL mr_xfer got v=%b d=%b exp 1/11", bus.axiov, bus.axiod);
        end
        rst = 1'b0;
        tick();
        total++;
        if (bus.gnt !== 2'b00 || bus.axiov !== 1'b0 || bus.axiod !== 2'b00 || bus.frame_count !== 16'd0 ||
            bus.busy !== 1'b0 || bus.state_dbg !== 2'd0) begin
            bad++; $display("FAIL mr_reset got gnt=%b v=%b d=%b cnt=%0d busy=%b st=%0d exp all zero",
                            bus.gnt, bus.axiov, bus.axiod, bus.frame_count, bus.busy, bus.state_dbg);
        end
        rst       = 1'b1;
        bus.axiiv = 2'b00;
        bus.req   = 2'b11;
        tick();
        total++;
        if (bus.gnt !== 2'b01) begin
            bad++; $display("FAIL mr_regrant got gnt=%b exp 01", bus.gnt);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        #1;
        total++;
        if (bus.frame_count !== 16'hFFFF) begin
            bad++; $display("FAIL wrap_preload got %h exp ffff", bus.frame_count);
        end
        bus.req = 2'b01;
        tick();
        bus.axiiv = 2'b01;
        bus.axiid = 4'b0010;
        bus.req   = 2'b00;
        tick();
        total++;
        if (bus.axiov !== 1'b1 || bus.axiod !== 2'b10) begin
            bad++; $display("FAIL wrap_data got v=%b d=%b exp 1/10", bus.axiov, bus.axiod);
        end
        bus.axiiv = 2'b00;
        tick();
        total++;
        if (bus.frame_count !== 16'h0000) begin
            bad++; $display("FAIL wrap_count got %h exp 0000", bus.frame_count);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_truncation();
        test_reset_midframe();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
